// File: rtl/store_memory_control_unit_if.sv
// Pipeline/memory-side bundle for the store control unit: store request,
// write beat, handshake and status.
interface store_memory_control_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic              is_store;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   store_data;
    logic              mem_ready;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_strb;
    logic              stall;
    logic              store_done;
    logic              misaligned_fault;

    modport master (
        output is_store, funct3, addr, store_data, mem_ready,
        input  mem_wen, mem_addr, mem_wdata, mem_strb, stall, store_done, misaligned_fault
    );

    modport slave (
        input  is_store, funct3, addr, store_data, mem_ready,
        output mem_wen, mem_addr, mem_wdata, mem_strb, stall, store_done, misaligned_fault
    );
endinterface

// File: rtl/store_memory_control_unit.sv
// MEM-stage store sequencer: lane-aligns SB/SH/SW data and drives one or two write beats.
// Optional macro MISALIGNED_STORE_SPLIT_EN: split word-crossing stores instead of rejecting misaligned ones.
module store_memory_control_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    store_memory_control_unit_if.slave   bus
);
    localparam int unsigned NB = XLEN / 8;

    typedef enum logic [1:0] {IDLE, WRITE1, WRITE2, DONE} state_t;

    state_t          state_q;
    logic            mem_wen_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [NB-1:0]   mem_strb_q;
    logic [XLEN-1:0] hi_wdata_q;
    logic [NB-1:0]   hi_strb_q;
    logic            split_q;
    logic            done_q;
    logic            fault_q;

    logic [1:0]        off;
    logic [NB-1:0]     size_m;
    logic [XLEN-1:0]   data_m;
    logic [2*NB-1:0]   mask8;
    logic [2*XLEN-1:0] data64;
    logic              split;
    logic              reject;

    // Size mask and zero-extended payload, shifted into the two-word window
    always_comb begin
        off    = bus.addr[1:0];
        size_m = '1;
        data_m = bus.store_data;
        case (bus.funct3)
            3'b000: begin
                size_m = NB'(4'b0001);
                data_m = {{(XLEN-8){1'b0}}, bus.store_data[7:0]};
            end
            3'b001: begin
                size_m = NB'(4'b0011);
                data_m = {{(XLEN-16){1'b0}}, bus.store_data[15:0]};
            end
            default: begin
                size_m = '1;
                data_m = bus.store_data;
            end
        endcase
        mask8  = {{NB{1'b0}}, size_m} << off;
        data64 = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
        split  = |mask8[2*NB-1:NB];
    end

`ifdef MISALIGNED_STORE_SPLIT_EN
    assign reject = 1'b0;
`else
    assign reject = ((bus.funct3 == 3'b001) && off[0]) ||
                    ((bus.funct3 != 3'b000) && (bus.funct3 != 3'b001) && (off != 2'b00));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_strb_q  <= '0;
            hi_wdata_q  <= '0;
            hi_strb_q   <= '0;
            split_q     <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    if (bus.is_store) begin
                        if (reject) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            state_q     <= WRITE1;
                            mem_wen_q   <= 1'b1;
                            mem_addr_q  <= {bus.addr[XLEN-1:2], 2'b00};
                            mem_strb_q  <= mask8[NB-1:0];
                            mem_wdata_q <= data64[XLEN-1:0];
                            hi_strb_q   <= mask8[2*NB-1:NB];
                            hi_wdata_q  <= data64[2*XLEN-1:XLEN];
                            split_q     <= split;
                        end
                    end
                end
                WRITE1: begin
                    if (bus.mem_ready) begin
                        if (split_q) begin
                            state_q     <= WRITE2;
                            mem_addr_q  <= mem_addr_q + XLEN'(4);
                            mem_strb_q  <= hi_strb_q;
                            mem_wdata_q <= hi_wdata_q;
                        end else begin
                            state_q     <= DONE;
                            mem_wen_q   <= 1'b0;
                            mem_addr_q  <= '0;
                            mem_strb_q  <= '0;
                            mem_wdata_q <= '0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                WRITE2: begin
                    if (bus.mem_ready) begin
                        state_q     <= DONE;
                        mem_wen_q   <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_strb_q  <= '0;
                        mem_wdata_q <= '0;
                        done_q      <= 1'b1;
                    end
                end
                DONE: begin
                    // is_store still present here belongs to the store just completed
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall = ((state_q == IDLE) && bus.is_store) ||
                       (state_q == WRITE1) || (state_q == WRITE2);

    assign bus.mem_wen          = mem_wen_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_wdata        = mem_wdata_q;
    assign bus.mem_strb         = mem_strb_q;
    assign bus.store_done       = done_q;
    assign bus.misaligned_fault = fault_q;
endmodule

// File: doc/store_memory_control_unit.md
Name: store_memory_control_unit

Overview:
- Store-side counterpart of the load data extender: the load path narrows and extends read data; this block aligns store data toward memory.
- Takes a store instruction's funct3, effective address and rs2 data, and drives the data-memory write port with a word address, byte strobes and lane-aligned write data.
- Sequences the write through a valid/ready handshake and stalls the pipeline until memory accepts the write.
- Sits in the MEM stage next to the load path.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- is_store  input  1  MEM-stage instruction is a store; held stable by the pipeline while stall=1.
- funct3  input  3  000 SB, 001 SH, 010 SW; any other value is treated as SW.
- addr  input  32  effective byte address.
- store_data  input  32  rs2 value; low byte/half/word used.
- mem_ready  input  1  memory accepts the current beat this cycle.
- mem_wen  output  1  write beat valid.
- mem_addr  output  32  word-aligned beat address.
- mem_wdata  output  32  lane-aligned write data.
- mem_strb  output  4  byte enables; bit i selects lane i (bits [8i+7:8i]).
- stall  output  1  hold the pipeline.
- store_done  output  1  one-cycle pulse when the store completes.
- misaligned_fault  output  1  one-cycle pulse when a misaligned store is rejected.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE; mem_wen, mem_addr, mem_wdata, mem_strb, store_done and misaligned_fault are all 0. stall follows its combinational equation, so it is 0 while is_store=0.
- Reset mid-operation: takes effect at the next clk edge. Any in-flight beat is abandoned and mem_wen is 0 from that edge. No store_done pulse is produced.
- States: IDLE, WRITE1, WRITE2, DONE.
- Capture (IDLE with is_store=1):
  - off = addr[1:0].
  - size mask m = 0001 (SB), 0011 (SH) or 1111 (SW/default).
  - 8-bit mask M = {4'b0,m} << off.
  - 64-bit data D = {32'b0, store_data} << (8*off). Bytes above the access size are zeroed before the shift.
  - Split is required when M[7:4] != 0.
  - Natural misalignment: SH with off[0]=1, or SW with off != 0.
- Transitions:
  - IDLE -> WRITE1 on is_store, unless the access is rejected (see Optional Feature).
  - WRITE1 -> WRITE2 on mem_ready when split, else -> DONE.
  - WRITE2 -> DONE on mem_ready.
  - DONE -> IDLE unconditionally.
  - is_store seen in DONE belongs to the completed instruction and is ignored.
- Beat outputs (registered):
  - WRITE1: mem_wen=1, mem_addr={addr[31:2],2'b00}, mem_strb=M[3:0], mem_wdata=D[31:0].
  - WRITE2: mem_wen=1, mem_addr = WRITE1 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); mem_strb=M[7:4]; mem_wdata=D[63:32].
  - All beat fields are held stable while mem_ready=0.
  - Unselected lanes of mem_wdata are 0.
- stall = (state==IDLE && is_store) || state==WRITE1 || state==WRITE2. stall is combinational and low in DONE.
- Latency: a single-beat store with mem_ready=1 completes with store_done 2 cycles after is_store is first seen. Each extra ready-low cycle and the second beat each add one cycle.
- store_done is 1 only in DONE.
- misaligned_fault is 1 only in DONE, and only for a rejected store.

Optional Feature:
- Macro: MISALIGNED_STORE_SPLIT_EN.
- Defined:
  - Every access proceeds to WRITE1, including naturally misaligned ones that fit in one word (e.g. SH off=1 gives strb 0110).
  - Word-crossing accesses are split into two beats as described above.
  - misaligned_fault is tied to 0.
- Undefined:
  - A naturally misaligned store goes IDLE -> DONE with no mem_wen.
  - DONE asserts store_done=1 and misaligned_fault=1 for that cycle.
  - WRITE2 is unreachable.

Test Plan:
- SB, addr=0x103, data=0xAABBCCDD, mem_ready=1 -> one beat: mem_addr=0x100, strb=1000, wdata=0xDD000000; store_done 2 cycles after is_store.
- SW, addr=0x200, data=0x12345678, mem_ready low 3 cycles -> mem_wen, stall and fields stable (0x200, 1111, 0x12345678) for 4 cycles; store_done one cycle after ready.
- SH, addr=0x102, data=0x0000BEEF -> strb=1100, wdata=0xBEEF0000. funct3=011 at addr=0x300 -> behaves as SW (strb=1111).
- Feature on: SW, addr=0x1001, data=0x11223344 -> beat1 0x1000 / 1110 / 0x22334400; beat2 0x1004 / 0001 / 0x00000011. At addr=0xFFFFFFFE, beat2 mem_addr=0x00000000.
- Feature off: SH, addr=0x105 -> mem_wen never asserted; store_done=1 and misaligned_fault=1 for one cycle; stall high for one cycle only.
- rst asserted during WRITE2 (mem_ready=0) -> next edge: mem_wen=0, IDLE, no store_done. A following SB at 0x0 writes strb=0001 normally.
